// File: rtl/seq_mult4.sv
// Sequential 4x4 unsigned shift-add multiplier that reuses one bit4_RCA as its partial-product adder.
// Define SEQ_MULT4_EARLY_EXIT_EN to finish as soon as the remaining multiplier bits are all zero.

module bit4_RCA (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] Sum,
  output logic       Cout
);
  logic carry;

  // A scalar carry threads through the loop, so the chain is a plain ripple with no self-dependent vector.
  always_comb begin
    Sum   = 4'b0000;
    carry = Cin;
    for (int i = 0; i < 4; i++) begin
      Sum[i] = A[i] ^ B[i] ^ carry;
      carry  = (A[i] & B[i]) | (carry & (A[i] ^ B[i]));
    end
    Cout = carry;
  end
endmodule

module seq_mult4 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       busy,
  output logic       done,
  output logic [7:0] product
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t     state_reg, state_next;
  logic [3:0] mcand_reg, mcand_next;
  logic [3:0] hi_reg, hi_next;
  logic [3:0] lo_reg, lo_next;
  logic [2:0] cnt_reg, cnt_next;
  logic [7:0] product_reg, product_next;

  logic [3:0] add_b;
  logic [3:0] sum;
  logic       cout;
  logic [7:0] step_val;
  logic       last_step;
  logic [7:0] aligned;

  assign add_b = lo_reg[0] ? mcand_reg : 4'b0000;

  bit4_RCA u_add (
    .A    (hi_reg),
    .B    (add_b),
    .Cin  (1'b0),
    .Sum  (sum),
    .Cout (cout)
  );

  // The adder carry becomes the new top bit, so the whole pair shifts right by one each step.
  assign step_val = {cout, sum, lo_reg[3:1]};

`ifdef SEQ_MULT4_EARLY_EXIT_EN
  // Unconsumed multiplier bits sit in lo[2-cnt:0] after this step; once they are zero, finish the shifts at once.
  assign last_step = ((lo_reg[3:1] & (3'b111 >> cnt_reg)) == 3'b000);
  assign aligned   = step_val >> (3'd3 - cnt_reg);
`else
  assign last_step = (cnt_reg == 3'd3);
  assign aligned   = step_val;
`endif

  always_comb begin
    state_next   = state_reg;
    mcand_next   = mcand_reg;
    hi_next      = hi_reg;
    lo_next      = lo_reg;
    cnt_next     = cnt_reg;
    product_next = product_reg;
    case (state_reg)
      IDLE, DONE: begin
        state_next = IDLE;
        if (start) begin
          mcand_next = a;
          lo_next    = b;
          hi_next    = 4'b0000;
          cnt_next   = 3'd0;
          state_next = RUN;
`ifdef SEQ_MULT4_EARLY_EXIT_EN
          if (b == 4'b0000) begin
            product_next = 8'h00;
            state_next   = DONE;
          end
`endif
        end
      end
      RUN: begin
        hi_next  = step_val[7:4];
        lo_next  = step_val[3:0];
        cnt_next = cnt_reg + 3'd1;
        if (last_step) begin
          product_next = aligned;
          state_next   = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      mcand_reg   <= 4'b0000;
      hi_reg      <= 4'b0000;
      lo_reg      <= 4'b0000;
      cnt_reg     <= 3'd0;
      product_reg <= 8'h00;
    end else begin
      state_reg   <= state_next;
      mcand_reg   <= mcand_next;
      hi_reg      <= hi_next;
      lo_reg      <= lo_next;
      cnt_reg     <= cnt_next;
      product_reg <= product_next;
    end
  end

  assign busy    = (state_reg == RUN);
  assign done    = (state_reg == DONE);
  assign product = product_reg;
endmodule

// File: tb/tb_seq_mult4.sv
// Directed bench for seq_mult4; expectations follow SEQ_MULT4_EARLY_EXIT_EN when it is defined.

module tb_seq_mult4;
  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       busy;
  logic       done;
  logic [7:0] product;

  int total = 0;
  int bad   = 0;

`ifdef SEQ_MULT4_EARLY_EXIT_EN
  localparam int LAT_13X1 = 1;
  localparam int LAT_9X0  = 0;
  localparam int BUSY_9X0 = 0;
  localparam int LAT_4X4  = 3;
`else
  localparam int LAT_13X1 = 4;
  localparam int LAT_9X0  = 4;
  localparam int BUSY_9X0 = 4;
  localparam int LAT_4X4  = 4;
`endif

  seq_mult4 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called one edge after acceptance; counts further edges until done and the busy cycles seen meanwhile.
  task automatic wait_done(output int lat, output int nbusy);
    lat   = 0;
    nbusy = 0;
    while (!done && lat < 20) begin
      if (busy) nbusy++;
      lat++;
      step();
    end
  endtask

  task automatic run_op(input logic [3:0] oa, input logic [3:0] ob, input string tag,
                        input int exp_lat, input int exp_busy, input logic [7:0] exp_p,
                        input bit poke);
    int lat, nbusy;
    a = oa; b = ob; start = 1'b1;
    step();
    start = 1'b0;
    if (poke) begin
      a = 4'd3; b = 4'd3; start = 1'b1;
      if (busy) nbusy = 1;
      step();
      start = 1'b0;
      wait_done(lat, nbusy);
      lat   = lat + 1;
      nbusy = nbusy + 1;
    end else begin
      wait_done(lat, nbusy);
    end
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_busy"}, nbusy, exp_busy);
    check({tag, "_prod"}, product, exp_p);
    step();
    check({tag, "_pulse"}, done, 1'b0);
    check({tag, "_hold"}, product, exp_p);
  endtask

  initial begin
    int lat, nbusy;
    bit seen;
    rst_n = 1'b0; start = 1'b0; a = 4'd0; b = 4'd0;
    #7;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_prod", product, 8'h00);
    step();
    rst_n = 1'b1;
    step();

    run_op(4'd15, 4'd15, "m15x15", 4, 4, 8'hE1, 1'b0);
    run_op(4'd5, 4'd10, "m5x10", 4, 4, 8'h32, 1'b1);

    a = 4'd7; b = 4'd9; start = 1'b1;
    step();
    start = 1'b0;
    wait_done(lat, nbusy);
    check("b2b_lat1", lat, 4);
    check("b2b_done1", done, 1'b1);
    check("b2b_prod1", product, 8'd63);
    a = 4'd4; b = 4'd4; start = 1'b1;
    step();
    start = 1'b0;
    check("b2b_accept", busy, 1'b1);
    check("b2b_mid", product, 8'd63);
    wait_done(lat, nbusy);
    check("b2b_lat2", lat, LAT_4X4);
    check("b2b_prod2", product, 8'd16);
    step();
    check("b2b_pulse", done, 1'b0);

    a = 4'd12; b = 4'd11; start = 1'b1;
    step();
    start = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_prod", product, 8'h00);
    step();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (done) seen = 1'b1;
      step();
    end
    check("mid_rst_nodone", seen, 1'b0);
    run_op(4'd12, 4'd11, "m12x11", 4, 4, 8'd132, 1'b0);

    run_op(4'd13, 4'd1, "m13x1", LAT_13X1, LAT_13X1, 8'd13, 1'b0);
    run_op(4'd9, 4'd0, "m9x0", LAT_9X0, BUSY_9X0, 8'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
